// File: rtl/cic_ctrl_pkg.sv
// Shared types and default widths for the CIC rate controller.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } cic_state_t;

    localparam int DIV_W_DEF    = 16;
    localparam int R_W_DEF      = 8;
    localparam int N_STAGES_DEF = 5;
    localparam int OUT_W_DEF    = 8;
    localparam int CAP_LAT_DEF  = 1;

endpackage

// File: rtl/rate_counter.sv
// Modulo counter: counts 0..load while enabled and flags the wrap cycle with tick.
module rate_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] load,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == load);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/cic_rate_ctrl.sv
// CIC decimator sequencer: integrator/comb enable strobes, start-up discard,
// and a one-entry output buffer toward the sample consumer.
module cic_rate_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int R_W      = R_W_DEF,
    parameter int N_STAGES = N_STAGES_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int CAP_LAT  = CAP_LAT_DEF
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic [R_W-1:0]   dec_cfg,
    input  logic [OUT_W-1:0] filt_y,
    input  logic             out_ready,
    output logic             int_en,
    output logic             comb_en,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic [1:0]       state_dbg
);

    localparam int WARM_W = (N_STAGES < 2) ? 1 : $clog2(N_STAGES);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(N_STAGES - 1);

    cic_state_t         state;
    logic [DIV_W-1:0]   div_q;
    logic [R_W-1:0]     dec_q;
    logic [WARM_W-1:0]  warm_cnt;
    logic [CAP_LAT-1:0] cap_pipe;

    logic running;
    logic start_acc;
    logic cnt_clr;
    logic div_tick;
    logic dec_tick;
    logic capture;

    assign running   = (state != IDLE);
    assign start_acc = start && !stop && (state == IDLE);
    assign cnt_clr   = start_acc || stop;
    // A capture still in flight when stop arrives is discarded with the run.
    assign capture   = cap_pipe[CAP_LAT-1] && !stop;

    assign busy      = running;
    assign state_dbg = state;

    rate_counter #(.W(DIV_W)) u_div (
        .clock  (clock),
        .nreset (nreset),
        .en     (running),
        .clr    (cnt_clr),
        .load   (div_q),
        .tick   (div_tick)
    );

    rate_counter #(.W(R_W)) u_dec (
        .clock  (clock),
        .nreset (nreset),
        .en     (div_tick),
        .clr    (cnt_clr),
        .load   (dec_q),
        .tick   (dec_tick)
    );

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state    <= IDLE;
            div_q    <= '0;
            dec_q    <= '0;
            warm_cnt <= '0;
            int_en   <= 1'b0;
            comb_en  <= 1'b0;
            cap_pipe <= '0;
        end else begin
            int_en      <= div_tick && !stop;
            comb_en     <= dec_tick && !stop;
            cap_pipe[0] <= comb_en && (state == RUN) && !stop;
            for (int i = 1; i < CAP_LAT; i++) begin
                cap_pipe[i] <= stop ? 1'b0 : cap_pipe[i-1];
            end

            if (stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= WARMUP;
                            div_q    <= div_cfg;
                            dec_q    <= dec_cfg;
                            warm_cnt <= '0;
                        end
                    end
                    WARMUP: begin
                        // The first N_STAGES comb outputs carry filter fill-up transient.
                        if (comb_en) begin
                            if (warm_cnt == WARM_LAST) begin
                                state <= RUN;
                            end else begin
                                warm_cnt <= warm_cnt + WARM_W'(1);
                            end
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // out_valid/out_ready: a sample transfers on any cycle where both are high;
    // while out_valid is high and out_ready is low, out_data holds steady and
    // out_valid stays high. A capture arriving into a full, unaccepted buffer is
    // dropped and recorded in overrun.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (capture) begin
                if (!out_valid || out_ready) begin
                    out_data  <= filt_y;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (start_acc) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl: strobe timing, warm-up discard, buffer and stop behaviour.
module tb_cic_rate_ctrl;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] div_cfg = '0;
    logic [7:0]  dec_cfg = '0;
    logic [7:0]  filt_y = '0;
    logic        out_ready = 1'b0;
    logic        int_en;
    logic        comb_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass = 0;
    logic [63:0] obs_int, obs_comb, obs_valid;
    logic [63:0] exp_int, exp_comb, exp_valid;
    logic        any_act;

    always #5 clock = ~clock;

    cic_rate_ctrl dut (
        .clock     (clock),
        .nreset    (nreset),
        .start     (start),
        .stop      (stop),
        .div_cfg   (div_cfg),
        .dec_cfg   (dec_cfg),
        .filt_y    (filt_y),
        .out_ready (out_ready),
        .int_en    (int_en),
        .comb_en   (comb_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    function automatic logic [7:0] yv(input int c);
        return 8'(c * 13 + 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_obs();
        obs_int = '0; obs_comb = '0; obs_valid = '0;
        exp_int = '0; exp_comb = '0; exp_valid = '0;
        any_act = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        nreset = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check({tag, "_outs"}, {int_en, comb_en, out_valid, busy, overrun, out_data}, 64'h0);
        check({tag, "_state"}, state_dbg, 2'd0);
        nreset = 1'b1;
    endtask

    task automatic start_run(input logic [15:0] d, input logic [7:0] r);
        @(negedge clock);
        div_cfg = d; dec_cfg = r; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    initial begin
        // power-on reset
        do_reset("por");

        // reset in the middle of RUN with a held sample and overrun set
        start_run(16'd0, 8'd0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            filt_y = yv(c);
        end
        check("t1_valid", out_valid, 1'b1);
        check("t1_overrun", overrun, 1'b1);
        check("t1_data", out_data, yv(8));
        do_reset("t1_rst");
        clear_obs();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            any_act = any_act | int_en | comb_en | busy;
        end
        check("t1_idle_quiet", any_act, 1'b0);

        // div=3 dec=3, cfg changed mid-run
        do_reset("t2_rst");
        clear_obs();
        start_run(16'd3, 8'd3);
        for (int c = 1; c <= 52; c++) begin
            @(negedge clock);
            if (c == 3) begin
                div_cfg = 16'd7;
                dec_cfg = 8'd0;
            end
            obs_int[c]  = int_en;
            obs_comb[c] = comb_en;
            exp_int[c]  = (c >= 5) && ((c - 5) % 4 == 0);
            exp_comb[c] = (c == 17) || (c == 33) || (c == 49);
        end
        check("t2_int", obs_int, exp_int);
        check("t2_comb", obs_comb, exp_comb);
        check("t2_state_warmup", state_dbg, 2'd1);

        // warm-up discard, capture latency, consumer always ready
        do_reset("t3_rst");
        clear_obs();
        out_ready = 1'b1;
        start_run(16'd0, 8'd1);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clock);
            obs_comb[c]  = comb_en;
            obs_valid[c] = out_valid;
            exp_comb[c]  = (c >= 3) && (c % 2 == 1);
            exp_valid[c] = (c == 15) || (c == 17);
            if (c == 11) check("t3_state_c11", state_dbg, 2'd1);
            if (c == 12) check("t3_state_c12", state_dbg, 2'd2);
            if (c == 15) check("t3_data_c15", out_data, yv(14));
            if (c == 17) check("t3_data_c17", out_data, yv(16));
            filt_y = yv(c);
        end
        check("t3_comb", obs_comb, exp_comb);
        check("t3_valid", obs_valid, exp_valid);

        // backpressure, overrun, single-cycle ready, then stop with a capture pending
        do_reset("t4_rst");
        clear_obs();
        start_run(16'd0, 8'd3);
        for (int c = 1; c <= 46; c++) begin
            @(negedge clock);
            obs_comb[c] = comb_en;
            exp_comb[c] = (c >= 5) && (c <= 37) && ((c - 5) % 4 == 0);
            if (c == 27) begin
                check("t4_valid_c27", out_valid, 1'b1);
                check("t4_data_c27", out_data, yv(26));
                check("t4_ovr_c27", overrun, 1'b0);
            end
            if (c == 31) begin
                check("t4_ovr_c31", overrun, 1'b1);
                check("t4_data_c31", out_data, yv(26));
                check("t4_valid_c31", out_valid, 1'b1);
            end
            if (c == 33) check("t4_valid_c33", out_valid, 1'b0);
            if (c == 35) begin
                check("t4_valid_c35", out_valid, 1'b1);
                check("t4_data_c35", out_data, yv(34));
            end
            if (c == 37) check("t4_valid_c37", out_valid, 1'b0);
            if (c == 38) check("t5_busy_c38", busy, 1'b1);
            if (c == 39) begin
                check("t5_valid_c39", out_valid, 1'b0);
                check("t5_data_c39", out_data, yv(34));
                check("t5_busy_c39", busy, 1'b0);
                check("t5_ovr_c39", overrun, 1'b1);
            end
            if (c >= 39) any_act = any_act | int_en | comb_en | busy | out_valid;
            filt_y    = yv(c);
            out_ready = (c == 32) || (c == 36);
            stop      = (c == 38);
        end
        check("t4_comb", obs_comb, exp_comb);
        check("t5_after_stop", any_act, 1'b0);

        // start and stop together in IDLE: stop wins
        clear_obs();
        @(negedge clock);
        start = 1'b1; stop = 1'b1;
        @(posedge clock);
        #1 start = 1'b0; stop = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            any_act = any_act | int_en | comb_en | busy;
        end
        check("t5_start_stop", any_act, 1'b0);
        check("t5_ovr_held", overrun, 1'b1);

        // dec=0 div=2: comb_en equals int_en, new start clears overrun
        clear_obs();
        start_run(16'd2, 8'd0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) check("t6_ovr_clr", overrun, 1'b0);
            obs_int[c]  = int_en;
            obs_comb[c] = comb_en;
            exp_int[c]  = (c >= 4) && ((c - 4) % 3 == 0);
            exp_comb[c] = (c >= 4) && ((c - 4) % 3 == 0);
        end
        check("t6_int", obs_int, exp_int);
        check("t6_comb", obs_comb, exp_comb);

        @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check("t6_stopped", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
